hub75_plane_scanner: RTL and testbench
======================================

// Module: hub75_plane_scanner
// PURPOSE
//  Parametrised successor of the combinational bit-plane selector for the LED-matrix panel.
//  - Walks every row pair, bit plane and column of a frame buffer.
//  - Shifts one bit plane of RGB data into the HUB75 panel, then latches it.
//  - Lights the plane for a binary-weighted time (BCM).
//  - Sits between the frame-buffer RAM (1-cycle read latency) and the panel connector.
// PARAMETERS
//  COLOR_DEPTH  4   bits per colour channel = number of bit planes
//  COLUMNS      64  pixels shifted per row
//  ROW_ADDR_W   5   row-pair address width (2**ROW_ADDR_W row pairs)
//  BASE_OE      8   clocks oe_n is held low for plane 0; plane p is lit BASE_OE<<p clocks
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  synchronous, active-high reset
//  run         in   1                  level; 1 = scan frames continuously
//  pix_addr    out  ROW_ADDR_W+clog2(COLUMNS)  {row, col}; RAM read address
//  pix_data    in   6*COLOR_DEPTH      RAM data, valid one clk after pix_addr
//  rgb_out     out  6                  {B1,G1,R1,B0,G0,R0} panel data
//  sclk        out  1                  panel shift clock
//  latch       out  1                  panel latch strobe
//  oe_n        out  1                  panel output enable, active low
//  row_addr    out  ROW_ADDR_W         panel row-pair select
//  busy        out  1                  1 whenever the FSM is not IDLE
//  frame_done  out  1                  1-clk pulse at the end of the last display of a frame
// BEHAVIOUR
//  - Reset values: rgb_out=0, sclk=0, latch=0, oe_n=1, row_addr=0, pix_addr=0, busy=0,
//    frame_done=0. Plane, column and row counters are 0; FSM is in IDLE.
//  - Data packing: channel c (0..5) bit b is pix_data[COLOR_DEPTH*c+b].
//    rgb_out[c] = pix_data[COLOR_DEPTH*c+plane].
//  - FSM states: IDLE, ADDR, LOAD, CLK, LATCH, DISPLAY.
//    - IDLE: when run=1, go to ADDR on the next clk.
//    - ADDR (sclk=0): drive pix_addr={row,col}.
//    - LOAD (sclk=0): register rgb_out from pix_data at the current plane.
//    - CLK (sclk=1): if col==COLUMNS-1, set col=0 and go to LATCH; else col++ and go to ADDR.
//      Each column therefore takes exactly 3 clks.
//    - LATCH (1 clk): latch=1, oe_n=1, row_addr<=row.
//    - DISPLAY: oe_n=0 for exactly BASE_OE<<plane clks. On the last DISPLAY clk the FSM
//      advances the plane. After plane COLOR_DEPTH-1, plane=0 and row++.
//  - No idle cycle between DISPLAY and the next ADDR. Per plane: 3*COLUMNS+1+(BASE_OE<<p) clks.
//  - oe_n is 1 in every state except DISPLAY, so shifting is always blanked.
//    row_addr changes only in LATCH, with oe_n=1.
//  - Row wrap: when row==2**ROW_ADDR_W-1 finishes plane COLOR_DEPTH-1, row wraps to 0 and
//    frame_done=1 for that clk. If run=0 at that point, go to IDLE; else go to ADDR.
//  - run falling mid-frame: the current frame completes, then the FSM idles.
//    run is sampled only in IDLE and at the frame end.
//  - rst at any point, including mid-DISPLAY: the next clk returns every output and
//    counter to its reset value, and oe_n goes to 1 immediately.
//  - Display counter width: COLOR_DEPTH-1+clog2(BASE_OE)+1 bits; no overflow at the max plane.
// STRUCTURE
//  - hub75_pkg:
//    - state enum: IDLE, ADDR, LOAD, CLK, LATCH, DISPLAY
//    - localparams CH_R0..CH_B1 = 0..5 (channel order)
//    - clog2 function
//  - Sub-module plane_bit_select: combinational generalisation of the old selector.
//    Parameter COLOR_DEPTH; inputs pix_data and plane; output 6-bit rgb.
//    hub75_plane_scanner instantiates it once.
// TESTING  (COLUMNS=4, COLOR_DEPTH=4, ROW_ADDR_W=1, BASE_OE=2, RAM model latency 1)
//  1. Hold rst, run=1 for 3 clks -> all outputs at reset values, busy=0, oe_n=1.
//  2. Every word 24'hFEDCBA -> rgb_out is 6'b101010 in plane 0, 6'b110011 in plane 1,
//     6'b111100 in plane 2, 6'b111111 in plane 3.
//  3. Count the oe_n low run per plane -> 2, 4, 8, 16 clks.
//     Exactly 4 sclk rising edges precede each latch pulse.
//  4. run=1 held -> frame_done pulses every 164 clks, first pulse 164 clks after the
//     first ADDR clk. row_addr sequence is 0,1,0.
//     oe_n is never 0 while sclk toggles or row_addr changes.
//  5. Drop run during row 0 plane 2 -> frame finishes with frame_done.
//     Next clk: busy=0, FSM in IDLE, no further sclk edges.
//  6. Assert rst for 1 clk during plane 3 DISPLAY -> next clk oe_n=1, row_addr=0, busy=0.
//     With run still 1, scanning restarts at row 0, plane 0, col 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: FSM state type, panel channel order and a clog2 helper for the HUB75 scanner
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, LOAD, CLK, LATCH, DISPLAY} state_t;
  localparam int CH_R0 = 0;
  localparam int CH_G0 = 1;
  localparam int CH_B0 = 2;
  localparam int CH_R1 = 3;
  localparam int CH_G1 = 4;
  localparam int CH_B1 = 5;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/plane_bit_select.sv
// plane_bit_select: picks bit 'plane' of each of the six colour channels in pix_data (in: pix_data, plane; out: rgb)
module plane_bit_select
  import hub75_pkg::*;
#(
  parameter int COLOR_DEPTH = 4
) (
  input  logic [6*COLOR_DEPTH-1:0]      pix_data,
  input  logic [clog2(COLOR_DEPTH)-1:0] plane,
  output logic [5:0]                    rgb
);
  for (genvar c = 0; c < 6; c++) begin : g_ch
    logic [COLOR_DEPTH-1:0] ch;
    assign ch = pix_data[COLOR_DEPTH*c +: COLOR_DEPTH];
    assign rgb[c] = ch[plane];
  end
endmodule

// File: rtl/hub75_plane_scanner.sv
// hub75_plane_scanner: BCM scan of a frame buffer onto a HUB75 panel (in: clk, rst, run, pix_data; out: pix_addr, rgb_out, sclk, latch, oe_n, row_addr, busy, frame_done)
module hub75_plane_scanner
  import hub75_pkg::*;
#(
  parameter int COLOR_DEPTH = 4,
  parameter int COLUMNS     = 64,
  parameter int ROW_ADDR_W  = 5,
  parameter int BASE_OE     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run,
  output logic [ROW_ADDR_W+clog2(COLUMNS)-1:0] pix_addr,
  input  logic [6*COLOR_DEPTH-1:0]            pix_data,
  output logic [5:0]                          rgb_out,
  output logic                                sclk,
  output logic                                latch,
  output logic                                oe_n,
  output logic [ROW_ADDR_W-1:0]               row_addr,
  output logic                                busy,
  output logic                                frame_done
);
  localparam int CW = clog2(COLUMNS);
  localparam int PW = clog2(COLOR_DEPTH);
  localparam int DW = COLOR_DEPTH - 1 + clog2(BASE_OE) + 1;
  state_t state;
  logic [CW-1:0] col;
  logic [PW-1:0] plane;
  logic [ROW_ADDR_W-1:0] row, nrow;
  logic [DW-1:0] dcnt;
  logic [5:0] rgb;
  logic last_col, last_plane, frame_end;
  plane_bit_select #(.COLOR_DEPTH(COLOR_DEPTH)) u_sel (.pix_data(pix_data), .plane(plane), .rgb(rgb));
  assign last_col   = col == CW'(COLUMNS - 1);
  assign last_plane = plane == PW'(COLOR_DEPTH - 1);
  assign frame_end  = last_plane && (&row);
  assign nrow       = last_plane ? row + 1'b1 : row;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      plane      <= '0;
      row        <= '0;
      dcnt       <= '0;
      pix_addr   <= '0;
      rgb_out    <= '0;
      sclk       <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      row_addr   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (run) begin
          state    <= ADDR;
          busy     <= 1'b1;
          pix_addr <= {row, col};
        end
        ADDR: state <= LOAD;
        LOAD: begin
          rgb_out <= rgb;
          sclk    <= 1'b1;
          state   <= CLK;
        end
        CLK: begin
          sclk <= 1'b0;
          if (last_col) begin
            col      <= '0;
            latch    <= 1'b1;
            row_addr <= row;
            state    <= LATCH;
          end else begin
            col      <= col + 1'b1;
            pix_addr <= {row, col + 1'b1};
            state    <= ADDR;
          end
        end
        LATCH: begin
          latch <= 1'b0;
          oe_n  <= 1'b0;
          dcnt  <= (DW'(BASE_OE) << plane) - 1'b1;
          state <= DISPLAY;
        end
        DISPLAY: if (dcnt != '0) dcnt <= dcnt - 1'b1;
        else begin
          oe_n       <= 1'b1;
          plane      <= last_plane ? '0 : plane + 1'b1;
          row        <= nrow;
          pix_addr   <= {nrow, col};
          frame_done <= frame_end;
          busy       <= !(frame_end && !run);
          state      <= (frame_end && !run) ? IDLE : ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_plane_scanner.sv
// tb_hub75_plane_scanner: randomized frame-buffer scan checked against an event-level panel model
module tb_hub75_plane_scanner;
  localparam int CD = 4, COLS = 4, RAW = 1, BOE = 2, ROWS = 2, FRAME = 164;
  logic clk = 0, rst = 1, run = 1;
  logic [2:0] pix_addr;
  logic [23:0] pix_data;
  logic [5:0] rgb_out;
  logic sclk, latch, oe_n, busy, frame_done;
  logic [0:0] row_addr;
  logic [23:0] mem [ROWS*COLS];
  int vectors = 0, errors = 0;
  int m_row, m_plane, m_col, sc_cnt, oe_len, cyc, t_start, fd_cnt;
  logic p_sclk, p_oe, p_busy;
  logic [0:0] p_row;
  logic [23:0] w;
  logic [5:0] e;
  logic [5:0] fedcba_exp [CD];

  hub75_plane_scanner #(.COLOR_DEPTH(CD), .COLUMNS(COLS), .ROW_ADDR_W(RAW), .BASE_OE(BOE)) dut (
    .clk(clk), .rst(rst), .run(run), .pix_addr(pix_addr), .pix_data(pix_data),
    .rgb_out(rgb_out), .sclk(sclk), .latch(latch), .oe_n(oe_n), .row_addr(row_addr),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pix_data <= mem[pix_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Panel-level model: tracks which row/plane/column should be on the wire from the
  // visible events (shift edges, latch, display windows, frame pulses).
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_row = 0; m_plane = 0; m_col = 0; sc_cnt = 0; oe_len = 0;
      p_sclk = 0; p_oe = 1; p_busy = 0; p_row = 0;
    end else begin
      if (sclk && !p_sclk) begin
        w = mem[m_row*COLS + m_col];
        for (int c = 0; c < 6; c++) e[c] = w[CD*c + m_plane];
        check("rgb", rgb_out, e);
        check("oe_during_shift", oe_n, 1);
        m_col = (m_col + 1) % COLS;
        sc_cnt++;
      end
      if (latch) begin
        check("sclk_per_latch", sc_cnt, COLS);
        check("latch_row_addr", row_addr, m_row);
        check("oe_during_latch", oe_n, 1);
        sc_cnt = 0;
      end
      if (row_addr != p_row) check("oe_on_row_change", {p_oe, oe_n}, 2'b11);
      if (!oe_n) oe_len++;
      else if (!p_oe) begin
        check("oe_len", oe_len, BOE << m_plane);
        oe_len = 0;
        if (m_plane == CD-1) begin
          m_plane = 0;
          m_row = (m_row + 1) % ROWS;
        end else m_plane++;
      end
      if (busy && !p_busy) t_start = cyc;
      if (frame_done) begin
        check("frame_period", cyc - t_start, FRAME);
        check("frame_wrap", m_row*CD + m_plane, 0);
        t_start = cyc;
        fd_cnt++;
      end
      p_sclk = sclk; p_oe = oe_n; p_busy = busy; p_row = row_addr;
    end
  end

  initial begin
    int n, f0;
    fedcba_exp[0] = 6'b101010; fedcba_exp[1] = 6'b110011;
    fedcba_exp[2] = 6'b111100; fedcba_exp[3] = 6'b111111;
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = 24'hFEDCBA;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_rgb", rgb_out, 0);
      check("rst_sclk", sclk, 0);
      check("rst_latch", latch, 0);
      check("rst_oe", oe_n, 1);
      check("rst_row_addr", row_addr, 0);
      check("rst_pix_addr", pix_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
    end
    @(posedge clk); #1 rst = 0;
    for (int p = 0; p < CD; p++) begin
      n = 0;
      while (!(sclk && m_plane == p) && n < 400) begin @(negedge clk); #1; n++; end
      check("wait_plane", n < 400, 1);
      check("fedcba_rgb", rgb_out, fedcba_exp[p]);
    end
    n = 0;
    while (!frame_done && n < 400) begin @(negedge clk); #1; n++; end
    check("wait_frame1", n < 400, 1);
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = $urandom & 24'hFFFFFF;
    f0 = fd_cnt;
    n = 0;
    while (fd_cnt < f0 + 2 && n < 800) begin @(negedge clk); #1; n++; end
    check("wait_frames", fd_cnt, f0 + 2);
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = $urandom & 24'hFFFFFF;
    n = 0;
    while (!(m_row == 0 && m_plane == 2) && n < 400) begin @(negedge clk); #1; n++; end
    check("wait_r0p2", n < 400, 1);
    @(posedge clk); #1 run = 0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!frame_done && n < 400);
    check("stop_frame_done", frame_done, 1);
    check("stop_busy", busy, 0);
    repeat (8) begin
      @(negedge clk); #1;
      check("idle_sclk", sclk, 0);
      check("idle_busy", busy, 0);
      check("idle_oe", oe_n, 1);
    end
    run = 1;
    n = 0;
    while (!(m_plane == 3 && !oe_n) && n < 400) begin @(negedge clk); #1; n++; end
    check("wait_p3_display", n < 400, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk); #1;
    check("midrst_oe", oe_n, 1);
    check("midrst_row_addr", row_addr, 0);
    check("midrst_busy", busy, 0);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); #1; n++; end
    check("restart_busy", busy, 1);
    check("restart_pix_addr", pix_addr, 0);
    f0 = fd_cnt;
    n = 0;
    while (fd_cnt == f0 && n < 400) begin @(negedge clk); #1; n++; end
    check("restart_frame", fd_cnt, f0 + 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
